// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the convolution window feeder
package conv_pkg;

  localparam int KSIZE  = 3;
  localparam int WIN_N  = KSIZE * KSIZE;
  localparam int DATA_W = 32;

  // Window geometry: row 0 is the oldest line, column KSIZE-1 takes the newest pixel.
  localparam int ROW_OLD = 0;
  localparam int ROW_MID = 1;
  localparam int ROW_NEW = KSIZE - 1;
  localparam int COL_NEW = KSIZE - 1;

  typedef logic [DATA_W-1:0] pix_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_e;

  function automatic int win_idx(input int row, input int col);
    return KSIZE * row + col;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - circular line delay returning the word pushed DEPTH pushes ago
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en_i,
  input  pix_t din_i,
  output pix_t dout_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  pix_t          mem_q [DEPTH];
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  // Read-before-write: the slot about to be overwritten holds the oldest word.
  assign dout_o = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// rtl/conv_window_feeder.sv - 3x3 raster window builder and handshake driver for convolution_core
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  input  logic [DATA_W-1:0] pix_data_i,
  output logic [DATA_W-1:0] value0_o,
  output logic [DATA_W-1:0] value1_o,
  output logic [DATA_W-1:0] value2_o,
  output logic [DATA_W-1:0] value3_o,
  output logic [DATA_W-1:0] value4_o,
  output logic [DATA_W-1:0] value5_o,
  output logic [DATA_W-1:0] value6_o,
  output logic [DATA_W-1:0] value7_o,
  output logic [DATA_W-1:0] value8_o,
  output logic              caculating_start_o,
  input  logic              caculating_done_i,
  input  logic [DATA_W-1:0] ret_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_MIN  = XW'(KSIZE - 1);
  localparam logic [YW-1:0] Y_MIN  = YW'(KSIZE - 1);

  state_e        state_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  pix_t          win_q [WIN_N];
  logic          win_last_q;
  logic          start_q;
  logic          out_valid_q;
  logic          out_last_q;
  pix_t          out_data_q;
  pix_t          lb0_dout;
  pix_t          lb1_dout;
  logic          accept;
  logic          win_valid;
  logic          slot_free;

  assign pix_ready_o = (state_q == ST_IDLE);
  assign accept      = pix_valid_i && pix_ready_o;
  assign win_valid   = (x_q >= X_MIN) && (y_q >= Y_MIN);
  assign slot_free   = !out_valid_q || out_ready_i;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  conv_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (accept),
    .din_i     (pix_data_i),
    .dout_o    (lb0_dout)
  );

  conv_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (accept),
    .din_i     (lb0_dout),
    .dout_o    (lb1_dout)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      x_q        <= '0;
      y_q        <= '0;
      win_last_q <= 1'b0;
      for (int i = 0; i < WIN_N; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (accept) begin
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < COL_NEW; c++) begin
            win_q[win_idx(r, c)] <= win_q[win_idx(r, c + 1)];
          end
        end
        win_q[win_idx(ROW_OLD, COL_NEW)] <= lb1_dout;
        win_q[win_idx(ROW_MID, COL_NEW)] <= lb0_dout;
        win_q[win_idx(ROW_NEW, COL_NEW)] <= pix_data_i;
        win_last_q <= (x_q == X_LAST) && (y_q == Y_LAST);
      end
    end
  end

  // Start stays high until the result lands in a free slot, so the core holds ret meanwhile.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept && win_valid) begin
            state_q <= ST_RUN;
            start_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (caculating_done_i && slot_free) begin
            out_data_q  <= ret_i;
            out_valid_q <= 1'b1;
            out_last_q  <= win_last_q;
            start_q     <= 1'b0;
            state_q     <= ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (!caculating_done_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  assign value0_o           = win_q[0];
  assign value1_o           = win_q[1];
  assign value2_o           = win_q[2];
  assign value3_o           = win_q[3];
  assign value4_o           = win_q[4];
  assign value5_o           = win_q[5];
  assign value6_o           = win_q[6];
  assign value7_o           = win_q[7];
  assign value8_o           = win_q[8];
  assign caculating_start_o = start_q;
  assign out_valid_o        = out_valid_q;
  assign out_data_o         = out_data_q;
  assign out_last_o         = out_last_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb/tb_conv_window_feeder.sv - self-checking bench for conv_window_feeder with a behavioural core
module tb_conv_window_feeder;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] pix_data;
  logic [31:0] v0, v1, v2, v3, v4, v5, v6, v7, v8;
  logic        start;
  logic        done;
  logic [31:0] ret;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  always #5 clk = ~clk;

  conv_window_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .pix_valid_i        (pix_valid),
    .pix_ready_o        (pix_ready),
    .pix_data_i         (pix_data),
    .value0_o           (v0),
    .value1_o           (v1),
    .value2_o           (v2),
    .value3_o           (v3),
    .value4_o           (v4),
    .value5_o           (v5),
    .value6_o           (v6),
    .value7_o           (v7),
    .value8_o           (v8),
    .caculating_start_o (start),
    .caculating_done_i  (done),
    .ret_i              (ret),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .out_data_o         (out_data),
    .out_last_o         (out_last)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] frame_px [NPIX];
  logic [31:0] exp_d [$];
  logic        exp_l [$];
  int          exp_s [$];
  logic [31:0] got_d [$];
  logic        got_l [$];
  int          got_s [$];
  int          acc_cnt = 0;
  int          viol = 0;
  int          wl_cycles = 0;
  int          idle_pct;
  int          hold_extra;
  int          pix_timeouts;
  bit          frame_sent;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // Behavioural convolution_core: done 3 cycles into start, released one cycle (+hold_extra) after start drops.
  int core_cnt = 0;
  int core_hold = 0;
  initial begin
    done = 1'b0;
    ret  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        done     = 1'b0;
        core_cnt = 0;
      end else if (start) begin
        if (!done) begin
          core_cnt++;
          if (core_cnt == 3) begin
            ret = 32'd1*v0 + 32'd2*v1 + 32'd3*v2 + 32'd4*v3 + 32'd5*v4
                + 32'd6*v5 + 32'd7*v6 + 32'd8*v7 + 32'd9*v8;
            done      = 1'b1;
            core_hold = 1 + hold_extra;
          end
        end
      end else begin
        core_cnt = 0;
        if (done) begin
          if (core_hold == 0) done = 1'b0;
          else core_hold--;
        end
      end
    end
  end

  // Observes handshakes, start rises and protocol rules between clock edges.
  initial begin
    bit prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_start = 1'b0;
      end else begin
        if (pix_valid && pix_ready) acc_cnt++;
        if (start && !prev_start) begin
          if (done) viol++;
          got_s.push_back(acc_cnt);
        end
        if (done && pix_ready) viol++;
        if (done && !start) wl_cycles++;
        if (out_valid && out_ready) begin
          got_d.push_back(out_data);
          got_l.push_back(out_last);
        end
        prev_start = start;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Reference: every window ending at (x>=2, y>=2) dotted with kernel 1..9 in raster order.
  task automatic build_expect(input int acc_base);
    logic [31:0] s;
    for (int y = 2; y < H; y++) begin
      for (int x = 2; x < W; x++) begin
        s = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            s += 32'(3*r + c + 1) * frame_px[(y-2+r)*W + (x-2+c)];
        exp_d.push_back(s);
        exp_l.push_back((x == W-1) && (y == H-1));
        exp_s.push_back(acc_base + y*W + x + 1);
      end
    end
  endtask

  task automatic clear_expect();
    exp_d.delete();
    exp_l.delete();
    exp_s.delete();
  endtask

  task automatic fill_basic();
    for (int i = 0; i < NPIX; i++) frame_px[i] = 32'(i + 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) frame_px[i] = $urandom_range(0, 4095);
  endtask

  task automatic set_basic_results();
    exp_d = '{32'd348, 32'd393, 32'd528, 32'd573};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
  endtask

  task automatic send_pixel(input logic [31:0] d);
    bit ok;
    int k;
    while ($urandom_range(0, 99) < idle_pct) begin
      pix_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b1;
    pix_data  = d;
    k  = 0;
    ok = 1'b0;
    while (!ok && k < 500) begin
      @(negedge clk);
      ok = pix_ready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!ok) pix_timeouts++;
    pix_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < NPIX; i++) send_pixel(frame_px[i]);
    frame_sent = 1'b1;
  endtask

  task automatic wait_results(input int gb, input int n);
    for (int k = 0; k < 3000 && (got_d.size() - gb) < n; k++) @(posedge clk);
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag, input int gb, input int sb);
    check({tag, "_count"}, 32'(got_d.size() - gb), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (gb + i < got_d.size()) begin
        check($sformatf("%s_data%0d", tag, i), got_d[gb+i], exp_d[i]);
        check($sformatf("%s_last%0d", tag, i), 32'(got_l[gb+i]), 32'(exp_l[i]));
      end
    end
    check({tag, "_starts"}, 32'(got_s.size() - sb), 32'(exp_s.size()));
    for (int i = 0; i < exp_s.size(); i++) begin
      if (sb + i < got_s.size())
        check($sformatf("%s_start_at%0d", tag, i), 32'(got_s[sb+i]), 32'(exp_s[i]));
    end
  endtask

  initial begin
    int gb, sb, ab, vb, wb, lasts;
    reset_n      = 1'b0;
    pix_valid    = 1'b0;
    pix_data     = '0;
    out_ready    = 1'b1;
    idle_pct     = 0;
    hold_extra   = 0;
    pix_timeouts = 0;
    frame_sent   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_ready", 32'(pix_ready), 32'd1);
    check("rst_start", 32'(start), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_value0", v0, 32'd0);
    check("rst_value8", v8, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame 1..16
    fill_basic();
    clear_expect();
    gb = got_d.size(); sb = got_s.size(); ab = acc_cnt;
    build_expect(ab);
    set_basic_results();
    send_frame();
    wait_results(gb, 4);
    compare("basic", gb, sb);
    check("basic_first_start_pixel", 32'(got_s[sb] - ab), 32'd11);

    // Back-pressure: sink stalls while the second window completes
    out_ready  = 1'b0;
    frame_sent = 1'b0;
    clear_expect();
    gb = got_d.size(); sb = got_s.size(); ab = acc_cnt;
    build_expect(ab);
    set_basic_results();
    fork
      send_frame();
    join_none
    for (int k = 0; k < 500 && !(done && start && out_valid); k++) @(negedge clk);
    check("bp_stall_reached", 32'(done && start && out_valid), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("bp_start_held", 32'(start), 32'd1);
      check("bp_pix_ready_low", 32'(pix_ready), 32'd0);
      check("bp_out_data_held", out_data, 32'd348);
      check("bp_out_valid_held", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 3000 && !frame_sent; k++) @(posedge clk);
    check("bp_frame_sent", 32'(frame_sent), 32'd1);
    wait_results(gb, 4);
    compare("bp", gb, sb);

    // Idle gaps with random pixels
    idle_pct = 50;
    fill_random();
    clear_expect();
    gb = got_d.size(); sb = got_s.size(); ab = acc_cnt;
    build_expect(ab);
    send_frame();
    wait_results(gb, 4);
    compare("idle", gb, sb);
    idle_pct = 0;

    // Slow done release
    hold_extra = 2;
    fill_random();
    clear_expect();
    gb = got_d.size(); sb = got_s.size(); ab = acc_cnt; vb = viol; wb = wl_cycles;
    build_expect(ab);
    send_frame();
    wait_results(gb, 4);
    compare("slow", gb, sb);
    check("slow_waitlow_cycles", 32'(wl_cycles - wb), 32'(4 * (1 + hold_extra)));
    check("slow_protocol", 32'(viol - vb), 32'd0);
    hold_extra = 0;

    // Mid-operation reset: result 1 parked in the slot, window 2 running
    out_ready = 1'b0;
    fill_basic();
    for (int i = 0; i < 12; i++) send_pixel(frame_px[i]);
    for (int k = 0; k < 200 && !start; k++) @(negedge clk);
    check("mid_in_run", 32'(start), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_start_cleared", 32'(start), 32'd0);
    check("mid_out_valid_cleared", 32'(out_valid), 32'd0);
    check("mid_pix_ready", 32'(pix_ready), 32'd1);
    check("mid_x_cleared", 32'(dut.x_q), 32'd0);
    check("mid_y_cleared", 32'(dut.y_q), 32'd0);
    check("mid_value4_cleared", v4, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear_expect();
    gb = got_d.size(); sb = got_s.size(); ab = acc_cnt;
    build_expect(ab);
    set_basic_results();
    send_frame();
    wait_results(gb, 4);
    compare("refeed", gb, sb);

    // Back-to-back identical random frames
    fill_random();
    clear_expect();
    gb = got_d.size(); sb = got_s.size(); ab = acc_cnt;
    build_expect(ab);
    build_expect(ab + NPIX);
    send_frame();
    send_frame();
    wait_results(gb, 8);
    compare("b2b", gb, sb);
    lasts = 0;
    for (int i = gb; i < got_l.size(); i++) lasts += int'(got_l[i]);
    check("b2b_last_count", 32'(lasts), 32'd2);

    check("pix_accept_timeouts", 32'(pix_timeouts), 32'd0);
    check("protocol_violations", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Streaming front end for `convolution_core`. It accepts a raster pixel stream, builds a 3x3 sliding window with two line buffers, and drives the core's value/start/done handshake. It captures each `ret` and presents it on a back-pressured result stream. It sits between the pixel source (DMA/Avalon-ST adapter) and the Qsys result sink.

## Interface
- `IMG_WIDTH`, 64: pixels per row, ≥3.
- `IMG_HEIGHT`, 64: rows per frame, ≥3.
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pix_valid`  in  1  input pixel valid.
- `pix_ready`  out  1  input pixel accepted when `pix_valid && pix_ready`.
- `pix_data`  in  32  pixel value.
- `value0`..`value8`  out  32 each  window to core; index = 3*row + col; row 0 is oldest, col 0 is leftmost.
- `caculating_start`  out  1  start level to core.
- `caculating_done`  in  1  done level from core.
- `ret`  in  32  core result.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out_data`  out  32  captured `ret`.
- `out_last`  out  1  marks the last window of a frame.

## Operation
- **Counters:** column `x` (0..IMG_WIDTH-1) and row `y` (0..IMG_HEIGHT-1).
  - Both advance on each accepted pixel.
  - `x` wraps to 0 and increments `y`; `y` wraps to 0 at frame end.
- **Window update on accept:**
  - Each window row shifts left.
  - Column 2 loads {line buffer 1 output, line buffer 0 output, `pix_data`} for rows 0/1/2.
  - `pix_data` is pushed into line buffer 0, and line buffer 0's output into line buffer 1.
- **Window valid:** the accepted pixel had `x>=2 && y>=2`.
  - Windows never straddle rows or frames; stale buffer data is masked by this gate.
- **FSM** (encoding in package):
  - IDLE: `pix_ready=1`, `caculating_start=0`. Accepting a window-valid pixel → RUN. Other accepts stay in IDLE.
  - RUN: `caculating_start=1`, `pix_ready=0`, `value*` held stable. When `caculating_done=1` and the output slot is free (`!out_valid`, or `out_valid && out_ready` this cycle), capture `ret` → `out_data`, set `out_valid`, set `out_last = (x,y of window pixel)==(W-1,H-1)`, → WAIT_LOW. Otherwise stay in RUN with start held; the core holds `ret`.
  - WAIT_LOW: `caculating_start=0`, `pix_ready=0`. → IDLE once `caculating_done==0`. Start is never re-raised while done is high.
- **Output slot:** single entry. `out_valid` clears on handshake unless a new capture occurs in the same cycle.
- **Arithmetic:** `ret` passes through unmodified; no width change.
- **Reset (asynchronous, any state):**
  - State → IDLE; `x`, `y`, window regs, `value*`, `out_data` → 0.
  - `out_valid`, `out_last`, `caculating_start` → 0.
  - `pix_ready` = 1 after reset, since state is IDLE.
  - Line buffer contents are not cleared.
  - Dropping start mid-computation returns the core to its idle state.

## Timing
- `pix_ready` is combinational from state; all other outputs are registered.
- Window-valid pixel accepted at edge T → `caculating_start` high after T.
- Core raises done 3 cycles after start rises → capture at the same edge.
- Start falls the next cycle; done falls one cycle later → IDLE.
- Throughput: 1 pixel/cycle outside windows; about 6 cycles per window pixel without back-pressure.
- Simultaneous `out_ready` handshake and new capture: both occur; `out_valid` stays 1.

## Structure
- Package `conv_pkg` holds:
  - FSM state typedef (IDLE/RUN/WAIT_LOW).
  - `KSIZE=3`.
  - Window index constants.
  - Data width 32.
- Sub-module `conv_line_buffer`:
  - Parameters DEPTH=IMG_WIDTH, 32-bit data.
  - Circular RAM with one push per enable.
  - Output = the word pushed DEPTH enables ago (read-before-write at the same address).
- Instantiated twice.

## Test plan
- **Basic frame:** W=H=4, pixels 1..16 streamed, bench core model uses kernel 1..9 and the 3-cycle done latency → results 348, 393, 528, 573 in order; `out_last` set only on 573; no starts before pixel 11.
- **Back-pressure:** same frame with `out_ready` low until the 2nd result is done → start stays high, `pix_ready` stays 0, and the 393 capture waits. After release, results are in order with none lost.
- **Idle gaps:** `pix_valid` random 50% duty → same four results; `x`/`y` do not advance on idle cycles.
- **Slow done release:** core model holds done 2 extra cycles after start falls → feeder stays in WAIT_LOW and no start pulse overlaps done high.
- **Mid-operation reset:** `reset_n` pulsed low in RUN → start, `out_valid`, and counters are 0 immediately. Refeeding the frame yields 348 as the first result.
- **Back-to-back frames:** two identical frames → identical result sequences; `out_last` once per frame; the second frame has no window before its `y=2,x=2` pixel.
